// File: rtl/liteeth_1rw1r_sram_gen.sv
// 1RW + 1R single-clock SRAM with a post-reset zeroing sweep, lane write masks and 1/2-cycle reads.
// Define LITEETH_SRAM_BYPASS_EN to forward same-cycle rw0 write data to a colliding r0 read.
module liteeth_1rw1r_sram_gen #(
   parameter int BITS         = 32,
   parameter int WORD_DEPTH   = 384,
   parameter int ADDR_WIDTH   = 9,
   parameter int WMASK_WIDTH  = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   init_busy_out,
   output logic                   addr_err_out,
   input  logic                   r0_ce_in,
   input  logic [ADDR_WIDTH-1:0]  r0_addr_in,
   output logic [BITS-1:0]        r0_rd_out,
   output logic                   r0_valid_out,
   input  logic                   rw0_ce_in,
   input  logic                   rw0_we_in,
   input  logic [ADDR_WIDTH-1:0]  rw0_addr_in,
   input  logic [BITS-1:0]        rw0_wd_in,
   input  logic [WMASK_WIDTH-1:0] rw0_wmask_in,
   output logic [BITS-1:0]        rw0_rd_out,
   output logic                   rw0_valid_out
);

   localparam int                    LANE_W    = BITS / WMASK_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(WORD_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORD_DEPTH - 1);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("liteeth_1rw1r_sram_gen: READ_LATENCY must be 1 or 2");
   end
   if (BITS % WMASK_WIDTH != 0) begin : g_bad_mask
      $error("liteeth_1rw1r_sram_gen: BITS must be divisible by WMASK_WIDTH");
   end

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_sweep;
   logic                  r_init_busy;
   logic                  r_addr_err;
   logic [BITS-1:0]       r_mem [0:WORD_DEPTH-1];

   logic [BITS-1:0] r_r0_d1, r_rw0_d1;
   logic            r_r0_v1, r_rw0_v1;

   logic            w_r0_acc, w_rw0_acc, w_wr;
   logic            w_r0_inr, w_rw0_inr;
   logic [BITS-1:0] w_bitmask, w_rw0_old, w_r0_word;

   assign w_r0_inr  = {1'b0, r0_addr_in}  < DEPTH_X;
   assign w_rw0_inr = {1'b0, rw0_addr_in} < DEPTH_X;
   assign w_r0_acc  = (r_state == ST_RUN) && r0_ce_in;
   assign w_rw0_acc = (r_state == ST_RUN) && rw0_ce_in;
   assign w_wr      = w_rw0_acc && rw0_we_in && w_rw0_inr;

   always_comb begin
      w_bitmask = '0;
      for (int i = 0; i < WMASK_WIDTH; i++)
         w_bitmask[i*LANE_W +: LANE_W] = {LANE_W{rw0_wmask_in[i]}};
      w_rw0_old = w_rw0_inr ? r_mem[rw0_addr_in] : '0;
      w_r0_word = w_r0_inr  ? r_mem[r0_addr_in]  : '0;
`ifdef LITEETH_SRAM_BYPASS_EN
      if (w_wr && w_r0_inr && (r0_addr_in == rw0_addr_in))
         w_r0_word = (w_r0_word & ~w_bitmask) | (rw0_wd_in & w_bitmask);
`endif
   end

   // Sweep transitions to RUN on the same edge that clears the last word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_sweep     <= '0;
         r_init_busy <= 1'b1;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_sweep == LAST_WORD) begin
                  r_state     <= ST_RUN;
                  r_sweep     <= '0;
                  r_init_busy <= 1'b0;
               end else begin
                  r_sweep <= r_sweep + ADDR_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Storage carries no reset; the sweep owns the write port while in INIT.
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT)
         r_mem[r_sweep] <= '0;
      else if (w_wr)
         r_mem[rw0_addr_in] <= (w_rw0_old & ~w_bitmask) | (rw0_wd_in & w_bitmask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_r0_d1    <= '0;
         r_r0_v1    <= 1'b0;
         r_rw0_d1   <= '0;
         r_rw0_v1   <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         r_r0_v1  <= w_r0_acc;
         r_rw0_v1 <= w_rw0_acc;
         if (w_r0_acc)  r_r0_d1  <= w_r0_word;
         if (w_rw0_acc) r_rw0_d1 <= w_rw0_old;
         if ((w_r0_acc && !w_r0_inr) || (w_rw0_acc && !w_rw0_inr))
            r_addr_err <= 1'b1;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [BITS-1:0] r_r0_d2, r_rw0_d2;
      logic            r_r0_v2, r_rw0_v2;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_r0_d2  <= '0;
            r_r0_v2  <= 1'b0;
            r_rw0_d2 <= '0;
            r_rw0_v2 <= 1'b0;
         end else begin
            r_r0_v2  <= r_r0_v1;
            r_rw0_v2 <= r_rw0_v1;
            if (r_r0_v1)  r_r0_d2  <= r_r0_d1;
            if (r_rw0_v1) r_rw0_d2 <= r_rw0_d1;
         end
      end
      assign r0_rd_out     = r_r0_d2;
      assign r0_valid_out  = r_r0_v2;
      assign rw0_rd_out    = r_rw0_d2;
      assign rw0_valid_out = r_rw0_v2;
   end else begin : g_lat1
      assign r0_rd_out     = r_r0_d1;
      assign r0_valid_out  = r_r0_v1;
      assign rw0_rd_out    = r_rw0_d1;
      assign rw0_valid_out = r_rw0_v1;
   end

   assign init_busy_out = r_init_busy;
   assign addr_err_out  = r_addr_err;

endmodule
